// File: rtl/ctrl_pkg.sv
// Shared definitions for the decode stage: ISA opcode map, ALU codes, machine
// states and the packed control-bundle layout.
package ctrl_pkg;

    localparam int OPW    = 5;
    localparam int MODEW  = 2;
    localparam int ALUOPW = 4;

    localparam logic [OPW-1:0] OP_HALT   = 5'b00000;
    localparam logic [OPW-1:0] OP_NOP    = 5'b00001;
    localparam logic [OPW-1:0] OP_SIIC   = 5'b00010;
    localparam logic [OPW-1:0] OP_RTI    = 5'b00011;
    localparam logic [OPW-1:0] OP_J      = 5'b00100;
    localparam logic [OPW-1:0] OP_ADDI   = 5'b01000;
    localparam logic [OPW-1:0] OP_SUBI   = 5'b01001;
    localparam logic [OPW-1:0] OP_XORI   = 5'b01010;
    localparam logic [OPW-1:0] OP_ANDNI  = 5'b01011;
    localparam logic [OPW-1:0] OP_BEQZ   = 5'b01100;
    localparam logic [OPW-1:0] OP_ST     = 5'b10000;
    localparam logic [OPW-1:0] OP_LD     = 5'b10001;
    localparam logic [OPW-1:0] OP_RARITH = 5'b11011;

    localparam logic [ALUOPW-1:0] ALU_PASS = 4'b0000;
    localparam logic [ALUOPW-1:0] ALU_ADD  = 4'b0100;
    localparam logic [ALUOPW-1:0] ALU_SUB  = 4'b0101;
    localparam logic [ALUOPW-1:0] ALU_XOR  = 4'b0110;
    localparam logic [ALUOPW-1:0] ALU_ANDN = 4'b0111;

    localparam logic [1:0] SRC_REG  = 2'b00;
    localparam logic [1:0] SRC_IMM5 = 2'b01;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_EXC    = 2'b01,
        ST_HALTED = 2'b10
    } state_e;

    // Bundle layout, LSB first
    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_ALUSRC   = 1;   // 2 bits
    localparam int CTRL_ALUOP    = 3;   // ALUOPW bits
    localparam int CTRL_MEMREAD  = 7;
    localparam int CTRL_MEMWRITE = 8;
    localparam int CTRL_MEMTOREG = 9;
    localparam int CTRL_BRANCH   = 10;
    localparam int CTRL_JUMP     = 11;
    localparam int CTRL_HALT     = 12;
    localparam int CTRL_SIIC     = 13;
    localparam int CTRL_RTI      = 14;
    localparam int CTRL_ERR      = 15;
    localparam int CTRL_W        = 16;

    function automatic logic is_serial(input logic [CTRL_W-1:0] c);
        return c[CTRL_HALT] | c[CTRL_SIIC] | c[CTRL_RTI];
    endfunction

endpackage

// File: rtl/ctrl_decode_comb.sv
// Pure combinational opcode/mode -> control bundle decoder. Shared with the
// single-cycle core, so it holds no state and knows nothing about the FSM.
module ctrl_decode_comb
    import ctrl_pkg::*;
(
    input  logic [OPW-1:0]    opcode,
    input  logic [MODEW-1:0]  mode,
    output logic [CTRL_W-1:0] ctrl
);

    logic              regwrite_s;
    logic [1:0]        alusrc_s;
    logic [ALUOPW-1:0] aluop_s;
    logic              memread_s;
    logic              memwrite_s;
    logic              memtoreg_s;
    logic              branch_s;
    logic              jump_s;
    logic              halt_s;
    logic              siic_s;
    logic              rti_s;
    logic              err_s;

    // Opcode map; anything not listed is an undefined opcode
    always_comb begin
        regwrite_s = 1'b0;
        alusrc_s   = SRC_REG;
        aluop_s    = ALU_PASS;
        memread_s  = 1'b0;
        memwrite_s = 1'b0;
        memtoreg_s = 1'b0;
        branch_s   = 1'b0;
        jump_s     = 1'b0;
        halt_s     = 1'b0;
        siic_s     = 1'b0;
        rti_s      = 1'b0;
        err_s      = 1'b0;
        case (opcode)
            OP_HALT: halt_s = 1'b1;
            OP_NOP:  regwrite_s = 1'b0;
            OP_SIIC: siic_s = 1'b1;
            OP_RTI:  rti_s  = 1'b1;
            OP_J:    jump_s = 1'b1;
            OP_BEQZ: branch_s = 1'b1;
            OP_ADDI, OP_SUBI, OP_XORI, OP_ANDNI: begin
                regwrite_s = 1'b1;
                alusrc_s   = SRC_IMM5;
                aluop_s    = {2'b01, opcode[1:0]};
            end
            OP_ST: begin
                alusrc_s   = SRC_IMM5;
                aluop_s    = ALU_ADD;
                memwrite_s = 1'b1;
            end
            OP_LD: begin
                regwrite_s = 1'b1;
                alusrc_s   = SRC_IMM5;
                aluop_s    = ALU_ADD;
                memread_s  = 1'b1;
                memtoreg_s = 1'b1;
            end
            OP_RARITH: begin
                regwrite_s = 1'b1;
                case (mode)
                    2'b00:   aluop_s = ALU_ADD;
                    2'b01:   aluop_s = ALU_SUB;
                    2'b10:   aluop_s = ALU_XOR;
                    2'b11:   aluop_s = ALU_ANDN;
                    default: aluop_s = ALU_PASS;
                endcase
            end
            default: err_s = 1'b1;
        endcase
    end

    // Pack fields at the package offsets
    always_comb begin
        ctrl                               = '0;
        ctrl[CTRL_REGWRITE]                = regwrite_s;
        ctrl[CTRL_ALUSRC +: 2]             = alusrc_s;
        ctrl[CTRL_ALUOP +: ALUOPW]         = aluop_s;
        ctrl[CTRL_MEMREAD]                 = memread_s;
        ctrl[CTRL_MEMWRITE]                = memwrite_s;
        ctrl[CTRL_MEMTOREG]                = memtoreg_s;
        ctrl[CTRL_BRANCH]                  = branch_s;
        ctrl[CTRL_JUMP]                    = jump_s;
        ctrl[CTRL_HALT]                    = halt_s;
        ctrl[CTRL_SIIC]                    = siic_s;
        ctrl[CTRL_RTI]                     = rti_s;
        ctrl[CTRL_ERR]                     = err_s;
    end

endmodule

// File: rtl/ctrl_decode_stage.sv
// Registered ID stage: decoded bundle held under valid/ready, RUN/EXC/HALTED
// machine-state FSM, and a saturating illegal-opcode counter.
module ctrl_decode_stage
    import ctrl_pkg::*;
#(
    parameter int ERRW = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPW-1:0]    in_opcode,
    input  logic [MODEW-1:0]  in_mode,
    input  logic              in_pc_valid,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        state,
    output logic              halted,
    output logic [ERRW-1:0]   err_count
);

    logic [CTRL_W-1:0] dec_ctrl_s;
    logic [CTRL_W-1:0] load_ctrl_s;
    logic [CTRL_W-1:0] out_ctrl_r;
    logic              out_valid_r;
    state_e            state_r;
    state_e            state_next_s;
    logic              halted_r;
    logic [ERRW-1:0]   err_count_r;
    logic              serial_held_s;
    logic              in_ready_s;
    logic              acc_s;
    logic              cons_s;

    ctrl_decode_comb u_decode (
        .opcode (in_opcode),
        .mode   (in_mode),
        .ctrl   (dec_ctrl_s)
    );

    assign serial_held_s = out_valid_r & is_serial(out_ctrl_r);
    assign in_ready_s    = (state_r != ST_HALTED) & ~serial_held_s &
                           (~out_valid_r | out_ready) & ~flush;
    assign acc_s         = in_valid & in_ready_s;
    assign cons_s        = out_valid_r & out_ready & ~flush;

    // Qualify HALT with pc_valid and resolve SIIC/RTI legality. Nothing can be
    // accepted behind a serial op, so the state seen here is the consume state.
    always_comb begin
        load_ctrl_s            = dec_ctrl_s;
        load_ctrl_s[CTRL_HALT] = dec_ctrl_s[CTRL_HALT] & in_pc_valid;
        load_ctrl_s[CTRL_ERR]  = dec_ctrl_s[CTRL_ERR] |
                                 (dec_ctrl_s[CTRL_RTI]  & (state_r == ST_RUN)) |
                                 (dec_ctrl_s[CTRL_SIIC] & (state_r == ST_EXC));
    end

    // Output register: flush beats load, load beats drain
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_ctrl_r  <= '0;
        end else if (flush) begin
            out_valid_r <= 1'b0;
        end else if (acc_s) begin
            out_valid_r <= 1'b1;
            out_ctrl_r  <= load_ctrl_s;
        end else if (cons_s) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Machine-state next-state logic, driven only by consumed bundles
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (cons_s && out_ctrl_r[CTRL_HALT]) begin
                    state_next_s = ST_HALTED;
                end else if (cons_s && out_ctrl_r[CTRL_SIIC]) begin
                    state_next_s = ST_EXC;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_EXC: begin
                if (cons_s && out_ctrl_r[CTRL_HALT]) begin
                    state_next_s = ST_HALTED;
                end else if (cons_s && out_ctrl_r[CTRL_RTI]) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_EXC;
                end
            end
            ST_HALTED: state_next_s = ST_HALTED;
            default:   state_next_s = ST_RUN;
        endcase
    end

    // State register and registered halted flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_RUN;
            halted_r <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            halted_r <= (state_next_s == ST_HALTED);
        end
    end

    // Saturating count of consumed bundles carrying ERR
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count_r <= '0;
        end else if (cons_s && out_ctrl_r[CTRL_ERR] && (err_count_r != {ERRW{1'b1}})) begin
            err_count_r <= err_count_r + {{(ERRW-1){1'b0}}, 1'b1};
        end else begin
            err_count_r <= err_count_r;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_ctrl  = out_ctrl_r;
    assign state     = state_r;
    assign halted    = halted_r;
    assign err_count = err_count_r;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Self-checking bench for ctrl_decode_stage: decode table through a scoreboard
// plus directed stall, HALT, SIIC/RTI, flush and counter-saturation sequences.
module tb_ctrl_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_opcode;
    logic [1:0]  in_mode;
    logic        in_pc_valid;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_ctrl;
    logic [1:0]  state;
    logic        halted;
    logic [7:0]  err_count;
    logic        in_ready2;
    logic        out_valid2;
    logic [15:0] out_ctrl2;
    logic [1:0]  state2;
    logic        halted2;
    logic [1:0]  err_count2;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic [15:0] exp_cur;
    logic [15:0] sb_q[$];
    logic [15:0] popped;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ctrl_decode_stage #(.ERRW(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_mode(in_mode), .in_pc_valid(in_pc_valid),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .state(state), .halted(halted), .err_count(err_count)
    );

    ctrl_decode_stage #(.ERRW(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_opcode(in_opcode), .in_mode(in_mode), .in_pc_valid(in_pc_valid),
        .flush(flush), .out_valid(out_valid2), .out_ready(out_ready),
        .out_ctrl(out_ctrl2), .state(state2), .halted(halted2), .err_count(err_count2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // bundle = {err,rti,siic,halt,jump,branch,memtoreg,memwrite,memread, aluop, alusrc, regwrite}
    function automatic logic [15:0] mk(input logic rw, input logic [1:0] src,
                                       input logic [3:0] op, input logic [8:0] flags);
        return {flags, op, src, rw};
    endfunction

    localparam logic [8:0] F_NONE = 9'b000000000;
    localparam logic [8:0] F_MR   = 9'b000000001;
    localparam logic [8:0] F_MW   = 9'b000000010;
    localparam logic [8:0] F_M2R  = 9'b000000100;
    localparam logic [8:0] F_BR   = 9'b000001000;
    localparam logic [8:0] F_J    = 9'b000010000;
    localparam logic [8:0] F_HALT = 9'b000100000;
    localparam logic [8:0] F_SIIC = 9'b001000000;
    localparam logic [8:0] F_RTI  = 9'b010000000;
    localparam logic [8:0] F_ERR  = 9'b100000000;

    // Scoreboard: expected bundles pushed on accept, popped on consume, dropped on flush
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
        end else begin
            check("out_valid", {31'd0, out_valid}, {31'd0, (sb_q.size() != 0)});
            if (out_valid && flush) begin
                if (sb_q.size() != 0) popped = sb_q.pop_front();
            end else if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    popped = sb_q.pop_front();
                    check("out_ctrl", {16'd0, out_ctrl}, {16'd0, popped});
                end
            end
            if (in_valid && in_ready) sb_q.push_back(exp_cur);
        end
    end

    task automatic send(input logic [4:0] op, input logic [1:0] md, input logic pcv,
                        input logic [15:0] exp);
        logic ok;
        in_valid    = 1'b1;
        in_opcode   = op;
        in_mode     = md;
        in_pc_valid = pcv;
        exp_cur     = exp;
        ok          = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [4:0]  op;
        logic [1:0]  md;
        logic        pcv;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   t0;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_opcode = 5'd0; in_mode = 2'd0;
        in_pc_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; exp_cur = 16'd0;

        vecs.push_back('{5'b01000, 2'b00, 1'b1, mk(1'b1, 2'b01, 4'b0100, F_NONE)});
        vecs.push_back('{5'b01001, 2'b00, 1'b1, mk(1'b1, 2'b01, 4'b0101, F_NONE)});
        vecs.push_back('{5'b01010, 2'b00, 1'b1, mk(1'b1, 2'b01, 4'b0110, F_NONE)});
        vecs.push_back('{5'b01011, 2'b00, 1'b1, mk(1'b1, 2'b01, 4'b0111, F_NONE)});
        vecs.push_back('{5'b11011, 2'b00, 1'b1, mk(1'b1, 2'b00, 4'b0100, F_NONE)});
        vecs.push_back('{5'b11011, 2'b00, 1'b1, mk(1'b1, 2'b00, 4'b0100, F_NONE)});
        vecs.push_back('{5'b11011, 2'b01, 1'b1, mk(1'b1, 2'b00, 4'b0101, F_NONE)});
        vecs.push_back('{5'b11011, 2'b10, 1'b1, mk(1'b1, 2'b00, 4'b0110, F_NONE)});
        vecs.push_back('{5'b11011, 2'b11, 1'b1, mk(1'b1, 2'b00, 4'b0111, F_NONE)});
        vecs.push_back('{5'b10000, 2'b00, 1'b1, mk(1'b0, 2'b01, 4'b0100, F_MW)});
        vecs.push_back('{5'b10001, 2'b00, 1'b1, mk(1'b1, 2'b01, 4'b0100, F_MR | F_M2R)});
        vecs.push_back('{5'b01100, 2'b00, 1'b1, mk(1'b0, 2'b00, 4'b0000, F_BR)});
        vecs.push_back('{5'b00100, 2'b00, 1'b1, mk(1'b0, 2'b00, 4'b0000, F_J)});
        vecs.push_back('{5'b00001, 2'b00, 1'b1, 16'h0000});
        vecs.push_back('{5'b00000, 2'b00, 1'b0, 16'h0000});
        vecs.push_back('{5'b11111, 2'b00, 1'b1, mk(1'b0, 2'b00, 4'b0000, F_ERR)});
        vecs.push_back('{5'b00101, 2'b10, 1'b1, mk(1'b0, 2'b00, 4'b0000, F_ERR)});

        // Reset state
        idle(2);
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_ctrl",  {16'd0, out_ctrl},  32'd0);
        check("rst_state",     {30'd0, state},     32'd0);
        check("rst_halted",    {31'd0, halted},    32'd0);
        check("rst_err_count", {24'd0, err_count}, 32'd0);

        // Decode table, back-to-back at full rate
        @(posedge clk); #1;
        t0 = cyc;
        foreach (vecs[i]) send(vecs[i].op, vecs[i].md, vecs[i].pcv, vecs[i].exp);
        check("stream_rate", cyc - t0, vecs.size());
        idle(3);
        check("table_err_count", {24'd0, err_count}, 32'd2);

        // Stall: LD held under out_ready=0, then consume + accept in one cycle
        out_ready = 1'b0;
        send(5'b10001, 2'b00, 1'b1, mk(1'b1, 2'b01, 4'b0100, F_MR | F_M2R));
        in_valid = 1'b1; in_opcode = 5'b01000; in_mode = 2'b00; in_pc_valid = 1'b1;
        exp_cur  = mk(1'b1, 2'b01, 4'b0100, F_NONE);
        repeat (3) begin
            @(negedge clk);
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            check("stall_out_ctrl", {16'd0, out_ctrl}, {16'd0, mk(1'b1, 2'b01, 4'b0100, F_MR | F_M2R)});
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("pipelined_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        idle(2);

        // HALT blocks ADDI, then machine halts permanently until reset
        out_ready = 1'b0;
        send(5'b00000, 2'b00, 1'b1, mk(1'b0, 2'b00, 4'b0000, F_HALT));
        in_valid = 1'b1; in_opcode = 5'b01000; in_mode = 2'b00; in_pc_valid = 1'b1;
        exp_cur  = mk(1'b1, 2'b01, 4'b0100, F_NONE);
        @(negedge clk);
        check("halt_held_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("halt_cons_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        check("halted_state", {30'd0, state}, 32'd2);
        check("halted_flag", {31'd0, halted}, 32'd1);
        repeat (3) begin
            @(negedge clk);
            check("halted_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        do_reset();
        @(negedge clk);
        check("post_rst_state", {30'd0, state}, 32'd0);
        check("post_rst_halted", {31'd0, halted}, 32'd0);
        check("post_rst_err", {24'd0, err_count}, 32'd0);

        // SIIC -> EXC, RTI -> RUN, then RTI in RUN is illegal
        @(posedge clk); #1;
        send(5'b00010, 2'b00, 1'b1, mk(1'b0, 2'b00, 4'b0000, F_SIIC));
        idle(1);
        @(negedge clk);
        check("siic_state", {30'd0, state}, 32'd1);
        @(posedge clk); #1;
        send(5'b00011, 2'b00, 1'b1, mk(1'b0, 2'b00, 4'b0000, F_RTI));
        idle(1);
        @(negedge clk);
        check("rti_state", {30'd0, state}, 32'd0);
        check("rti_err", {24'd0, err_count}, 32'd0);
        @(posedge clk); #1;
        send(5'b00011, 2'b00, 1'b1, mk(1'b0, 2'b00, 4'b0000, F_RTI | F_ERR));
        idle(1);
        @(negedge clk);
        check("rti_run_state", {30'd0, state}, 32'd0);
        check("rti_run_err", {24'd0, err_count}, 32'd1);

        // Flushed SIIC causes no side effects
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(5'b00010, 2'b00, 1'b1, mk(1'b0, 2'b00, 4'b0000, F_SIIC));
        flush = 1'b1;
        @(negedge clk);
        check("flush_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        check("flush_state", {30'd0, state}, 32'd0);
        check("flush_err", {24'd0, err_count}, 32'd1);

        // Saturation: five illegal opcodes into the 2-bit counter
        do_reset();
        for (int i = 0; i < 5; i++) send(5'b11111, 2'b00, 1'b1, mk(1'b0, 2'b00, 4'b0000, F_ERR));
        idle(3);
        check("sat_err2", {30'd0, err_count2}, 32'd3);
        check("sat_err8", {24'd0, err_count}, 32'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
